// File: rtl/rsp_ld_pkg.sv
// rsp_ld_pkg
// Shared definitions for the RSP scalar register-array load arbiter:
// register count, register address width, write source encoding and the
// 5-to-32 one-hot decoder used to form load strobes and pending masks.
package rsp_ld_pkg;

   localparam int unsigned RSP_NREG    = 32;
   localparam int unsigned RSP_RADDR_W = 5;

   typedef enum logic {
      LD_SRC_EX = 1'b0,
      LD_SRC_DM = 1'b1
   } ld_src_t;

   function automatic logic [RSP_NREG-1:0] onehot5(input logic [RSP_RADDR_W-1:0] addr);
      logic [RSP_NREG-1:0] oh;
      oh       = '0;
      oh[addr] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/rsp_ld_q.sv
// rsp_ld_q
// Holding queue for memory returns that lost write-port arbitration.
// Entries stay compacted so the head is always slot 0; a kill removes every
// entry whose address matches, wherever it sits, and the survivors close up.
//
// Ports:
//   clk, reset_l            clock, synchronous active-low reset
//   push/push_addr/push_data enqueue a return at the tail (ignored when full)
//   pop                     remove the head (it is being written this cycle)
//   kill/kill_addr          drop all entries targeting kill_addr
//   head_valid/addr/data    current head entry
//   occ_next                occupancy after this cycle's updates
//   pend_mask               registered one-hot OR of queued addresses
module rsp_ld_q
   import rsp_ld_pkg::*;
#(
   parameter  int unsigned QDEPTH = 2,
   parameter  int unsigned DW     = 32,
   parameter  int unsigned NREG   = RSP_NREG,
   localparam int unsigned OCCW   = $clog2(QDEPTH + 1)
) (
   input  logic                   clk,
   input  logic                   reset_l,
   input  logic                   push,
   input  logic [RSP_RADDR_W-1:0] push_addr,
   input  logic [DW-1:0]          push_data,
   input  logic                   pop,
   input  logic                   kill,
   input  logic [RSP_RADDR_W-1:0] kill_addr,
   output logic                   head_valid,
   output logic [RSP_RADDR_W-1:0] head_addr,
   output logic [DW-1:0]          head_data,
   output logic [OCCW-1:0]        occ_next,
   output logic [NREG-1:0]        pend_mask
);

   logic [QDEPTH-1:0]      q_valid, n_valid;
   logic [RSP_RADDR_W-1:0] q_addr [QDEPTH];
   logic [RSP_RADDR_W-1:0] n_addr [QDEPTH];
   logic [DW-1:0]          q_data [QDEPTH];
   logic [DW-1:0]          n_data [QDEPTH];
   logic [NREG-1:0]        n_pend;
   logic [RSP_NREG-1:0]    oh_tmp;
   int unsigned            keep_cnt;

   assign head_valid = q_valid[0];
   assign head_addr  = q_addr[0];
   assign head_data  = q_data[0];

   // Survivors are copied in order into slots 0..keep_cnt-1, then the push
   // lands right behind them; this keeps FIFO order across kills.
   always_comb begin
      n_valid  = '0;
      n_pend   = '0;
      oh_tmp   = '0;
      keep_cnt = 0;
      for (int unsigned j = 0; j < QDEPTH; j++) begin
         n_addr[j] = '0;
         n_data[j] = '0;
      end
      for (int unsigned i = 0; i < QDEPTH; i++) begin
         if (q_valid[i] && !(pop && i == 0) && !(kill && q_addr[i] == kill_addr)) begin
            for (int unsigned j = 0; j < QDEPTH; j++) begin
               if (j == keep_cnt) begin
                  n_valid[j] = 1'b1;
                  n_addr[j]  = q_addr[i];
                  n_data[j]  = q_data[i];
               end
            end
            keep_cnt = keep_cnt + 1;
         end
      end
      if (push && keep_cnt < QDEPTH) begin
         for (int unsigned j = 0; j < QDEPTH; j++) begin
            if (j == keep_cnt) begin
               n_valid[j] = 1'b1;
               n_addr[j]  = push_addr;
               n_data[j]  = push_data;
            end
         end
         keep_cnt = keep_cnt + 1;
      end
      for (int unsigned j = 0; j < QDEPTH; j++) begin
         if (n_valid[j]) begin
            oh_tmp = onehot5(n_addr[j]);
            n_pend = n_pend | oh_tmp[NREG-1:0];
         end
      end
      occ_next = OCCW'(keep_cnt);
   end

   always_ff @(posedge clk) begin
      if (!reset_l) begin
         q_valid   <= '0;
         pend_mask <= '0;
         for (int unsigned j = 0; j < QDEPTH; j++) begin
            q_addr[j] <= '0;
            q_data[j] <= '0;
         end
      end else begin
         q_valid   <= n_valid;
         q_addr    <= n_addr;
         q_data    <= n_data;
         pend_mask <= n_pend;
      end
   end

endmodule

// File: rtl/rsp_ld_arb.sv
// rsp_ld_arb
// Write-port load arbiter for the RSP scalar register latch array. Picks one
// writer per cycle among execute results, queued memory returns and bypassed
// memory returns, enforces write-after-write ordering, and drives registered
// active-low load strobes into the array's NOR clock gates.
//
// Ports:
//   clk, reset_l                 clock, synchronous active-low reset
//   ex_valid/ex_addr/ex_data     execute writeback request
//   ex_stall                     execute not accepted (head has starved)
//   dm_valid/dm_addr/dm_data     memory return request (legal only if dm_ready)
//   dm_ready                     holding queue can absorb a return
//   ld_bar                       per-register active-low load strobe
//   wr_data                      data presented to the array
//   wr_src                       0 = execute, 1 = memory
//   pend_mask                    registers with a queued memory write
module rsp_ld_arb
   import rsp_ld_pkg::*;
#(
   parameter int unsigned NREG       = RSP_NREG,
   parameter int unsigned DW         = 32,
   parameter int unsigned QDEPTH     = 2,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic                   clk,
   input  logic                   reset_l,
   input  logic                   ex_valid,
   input  logic [RSP_RADDR_W-1:0] ex_addr,
   input  logic [DW-1:0]          ex_data,
   output logic                   ex_stall,
   input  logic                   dm_valid,
   input  logic [RSP_RADDR_W-1:0] dm_addr,
   input  logic [DW-1:0]          dm_data,
   output logic                   dm_ready,
   output logic [NREG-1:0]        ld_bar,
   output logic [DW-1:0]          wr_data,
   output logic                   wr_src,
   output logic [NREG-1:0]        pend_mask
);

   localparam int unsigned OCCW = $clog2(QDEPTH + 1);
   localparam int unsigned AGEW = $clog2(STARVE_MAX + 1);
   localparam logic [AGEW-1:0] AGE_LIM = AGEW'(STARVE_MAX - 1);

   logic                   ex_acc, dm_acc;
   logic                   ex_win, dm_win, pop;
   logic                   dm_drop, push, head_killed;
   logic                   q_head_valid;
   logic [RSP_RADDR_W-1:0] q_head_addr;
   logic [DW-1:0]          q_head_data;
   logic [OCCW-1:0]        q_occ_next;
   logic                   w_valid, strobe;
   logic [RSP_RADDR_W-1:0] w_addr;
   logic [DW-1:0]          w_data;
   ld_src_t                w_src;
   logic [RSP_NREG-1:0]    oh_w;
   logic [AGEW-1:0]        age_q, age_n;
   logic                   stall_n;

   // Arbitration: a stalled execute yields to the head; otherwise execute,
   // then head, then a bypassed return. A return is always older than a
   // concurrent execute write, so an accepted execute kills matching returns.
   always_comb begin
      ex_acc = ex_valid & ~ex_stall;
      dm_acc = dm_valid & dm_ready;
      ex_win = 1'b0;
      dm_win = 1'b0;
      pop    = 1'b0;
      if (ex_stall)          pop    = q_head_valid;
      else if (ex_acc)       ex_win = 1'b1;
      else if (q_head_valid) pop    = 1'b1;
      else if (dm_acc)       dm_win = 1'b1;
      dm_drop     = ex_acc && (dm_addr == ex_addr);
      push        = dm_acc && !dm_win && !dm_drop && (dm_addr != '0);
      head_killed = ex_acc && q_head_valid && (q_head_addr == ex_addr);
   end

   always_comb begin
      w_valid = 1'b1;
      w_addr  = ex_addr;
      w_data  = ex_data;
      w_src   = LD_SRC_EX;
      if (pop) begin
         w_addr = q_head_addr;
         w_data = q_head_data;
         w_src  = LD_SRC_DM;
      end else if (dm_win) begin
         w_addr = dm_addr;
         w_data = dm_data;
         w_src  = LD_SRC_DM;
      end else if (!ex_win) begin
         w_valid = 1'b0;
      end
      strobe = w_valid && (w_addr != '0);
      oh_w   = onehot5(w_addr);
   end

   // Age tracks how long the current head has waited; any change of head
   // (pop, kill, or a fresh enqueue into an empty queue) restarts it.
   always_comb begin
      if (q_occ_next == '0 || !q_head_valid || pop || head_killed)
         age_n = '0;
      else if (age_q < AGE_LIM)
         age_n = age_q + 1'b1;
      else
         age_n = age_q;
      stall_n = (q_occ_next != '0) && (age_n >= AGE_LIM);
   end

   rsp_ld_q #(
      .QDEPTH (QDEPTH),
      .DW     (DW),
      .NREG   (NREG)
   ) u_q (
      .clk        (clk),
      .reset_l    (reset_l),
      .push       (push),
      .push_addr  (dm_addr),
      .push_data  (dm_data),
      .pop        (pop),
      .kill       (ex_acc),
      .kill_addr  (ex_addr),
      .head_valid (q_head_valid),
      .head_addr  (q_head_addr),
      .head_data  (q_head_data),
      .occ_next   (q_occ_next),
      .pend_mask  (pend_mask)
   );

   // Strobes and data come straight from flops so ld_bar only moves at the
   // rising edge and is settled before the low-phase gated enable.
   always_ff @(posedge clk) begin
      if (!reset_l) begin
         ld_bar   <= '1;
         wr_data  <= '0;
         wr_src   <= 1'b0;
         ex_stall <= 1'b0;
         dm_ready <= 1'b1;
         age_q    <= '0;
      end else begin
         ld_bar <= strobe ? ~oh_w[NREG-1:0] : '1;
         if (strobe) begin
            wr_data <= w_data;
            wr_src  <= (w_src == LD_SRC_DM);
         end
         ex_stall <= stall_n;
         dm_ready <= (q_occ_next < OCCW'(QDEPTH));
         age_q    <= age_n;
      end
   end

endmodule

// File: tb/tb_rsp_ld_arb.sv
module tb_rsp_ld_arb;

   localparam int NREG       = 32;
   localparam int DW         = 32;
   localparam int QDEPTH     = 2;
   localparam int STARVE_MAX = 4;

   logic        clk = 1'b0;
   logic        reset_l;
   logic        ex_valid, dm_valid;
   logic [4:0]  ex_addr, dm_addr;
   logic [31:0] ex_data, dm_data;
   logic        ex_stall, dm_ready, wr_src;
   logic [31:0] ld_bar, wr_data, pend_mask;

   always #5 clk = ~clk;

   rsp_ld_arb #(
      .NREG       (NREG),
      .DW         (DW),
      .QDEPTH     (QDEPTH),
      .STARVE_MAX (STARVE_MAX)
   ) dut (
      .clk       (clk),
      .reset_l   (reset_l),
      .ex_valid  (ex_valid),
      .ex_addr   (ex_addr),
      .ex_data   (ex_data),
      .ex_stall  (ex_stall),
      .dm_valid  (dm_valid),
      .dm_addr   (dm_addr),
      .dm_data   (dm_data),
      .dm_ready  (dm_ready),
      .ld_bar    (ld_bar),
      .wr_data   (wr_data),
      .wr_src    (wr_src),
      .pend_mask (pend_mask)
   );

   // Reference model: a queue of pending returns, each tagged with a serial id
   // so "how long has this particular return been at the front" is explicit.
   typedef struct {
      logic [4:0]  addr;
      logic [31:0] data;
      int          id;
   } ent_t;

   ent_t        mq[$];
   int          next_id = 0;
   int          m_wait  = 0;
   logic        m_stall = 1'b0;
   logic        m_ready = 1'b1;
   logic [31:0] e_ld_bar, e_wr_data, e_pend;
   logic        e_wr_src;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   task automatic model_step();
      bit          ex_acc, dm_acc;
      int          src;       // 0 none, 1 execute, 2 queue head, 3 bypass
      int          head_before;
      logic [4:0]  w_addr;
      logic [31:0] w_data;
      logic        w_src;
      ent_t        keep[$];
      ent_t        e;
      if (!reset_l) begin
         mq.delete();
         m_wait    = 0;
         m_stall   = 1'b0;
         m_ready   = 1'b1;
         e_ld_bar  = '1;
         e_wr_data = '0;
         e_wr_src  = 1'b0;
         e_pend    = '0;
         return;
      end
      head_before = (mq.size() != 0) ? mq[0].id : -1;
      ex_acc = ex_valid && !m_stall;
      dm_acc = dm_valid && m_ready;
      src = 0;
      if (m_stall)             src = (mq.size() != 0) ? 2 : 0;
      else if (ex_acc)         src = 1;
      else if (mq.size() != 0) src = 2;
      else if (dm_acc)         src = 3;
      w_addr = '0; w_data = '0; w_src = 1'b0;
      case (src)
         1: begin w_addr = ex_addr;    w_data = ex_data;    w_src = 1'b0; end
         2: begin w_addr = mq[0].addr; w_data = mq[0].data; w_src = 1'b1; end
         3: begin w_addr = dm_addr;    w_data = dm_data;    w_src = 1'b1; end
         default: ;
      endcase
      if (src == 2) void'(mq.pop_front());
      if (ex_acc) begin
         foreach (mq[i]) if (mq[i].addr != ex_addr) keep.push_back(mq[i]);
         mq = keep;
      end
      if (dm_acc && src != 3 && !(ex_acc && dm_addr == ex_addr) && dm_addr != 0) begin
         e.addr = dm_addr; e.data = dm_data; e.id = next_id;
         next_id++;
         mq.push_back(e);
      end
      if (mq.size() != 0 && mq[0].id == head_before) m_wait++;
      else m_wait = 0;
      m_stall = (mq.size() != 0) && (m_wait >= STARVE_MAX - 1);
      m_ready = (mq.size() < QDEPTH);
      e_pend = '0;
      foreach (mq[i]) e_pend |= 32'd1 << mq[i].addr;
      if (src != 0 && w_addr != 0) begin
         e_ld_bar  = ~(32'd1 << w_addr);
         e_wr_data = w_data;
         e_wr_src  = w_src;
      end else begin
         e_ld_bar = '1;
      end
   endtask

   task automatic check_all();
      chk("ld_bar",    ld_bar,              e_ld_bar);
      chk("wr_data",   wr_data,             e_wr_data);
      chk("wr_src",    {31'b0, wr_src},     {31'b0, e_wr_src});
      chk("ex_stall",  {31'b0, ex_stall},   {31'b0, m_stall});
      chk("dm_ready",  {31'b0, dm_ready},   {31'b0, m_ready});
      chk("pend_mask", pend_mask,           e_pend);
      chk("one_low",   {31'b0, ($countones(~ld_bar) <= 1)}, 32'd1);
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic set_in(input logic exv, input logic [4:0] exa, input logic [31:0] exd,
                         input logic dmv, input logic [4:0] dma, input logic [31:0] dmd);
      ex_valid = exv; ex_addr = exa; ex_data = exd;
      dm_valid = dmv; dm_addr = dma; dm_data = dmd;
   endtask

   task automatic idle();
      set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
   endtask

   function automatic logic [4:0] pick();
      if ($urandom_range(0, 1) != 0) return 5'($urandom_range(0, 3));
      return 5'($urandom_range(0, 31));
   endfunction

   initial begin
      reset_l = 1'b0;
      idle();
      tick();
      tick();
      chk("rst_ld_bar", ld_bar, 32'hFFFF_FFFF);
      reset_l = 1'b1;
      tick();

      // execute-only write
      set_in(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0);
      tick();
      chk("ex_r5_ld_bar", ld_bar, ~(32'd1 << 5));
      chk("ex_r5_data", wr_data, 32'hDEAD_BEEF);
      chk("ex_r5_src", {31'b0, wr_src}, 32'd0);
      idle(); tick();

      // address 0 from either source
      set_in(1'b1, 5'd0, 32'h1111_1111, 1'b0, 5'd0, 32'd0); tick();
      chk("ex_r0_nostrobe", ld_bar, 32'hFFFF_FFFF);
      set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h2222_2222); tick();
      chk("dm_r0_nostrobe", ld_bar, 32'hFFFF_FFFF);
      idle(); tick();

      // collision: ex r3 wins, dm r7 follows
      set_in(1'b1, 5'd3, 32'hA3, 1'b1, 5'd7, 32'hB7); tick();
      chk("coll_ex_strobe", ld_bar, ~(32'd1 << 3));
      chk("coll_pend7", pend_mask, 32'd1 << 7);
      idle(); tick();
      chk("coll_dm_strobe", ld_bar, ~(32'd1 << 7));
      chk("coll_dm_src", {31'b0, wr_src}, 32'd1);
      chk("coll_dm_data", wr_data, 32'hB7);
      idle(); tick();

      // WAW kill of a queued entry
      set_in(1'b1, 5'd2, 32'hA2, 1'b1, 5'd9, 32'hB9); tick();
      chk("kill_pend_set", pend_mask, 32'd1 << 9);
      set_in(1'b1, 5'd9, 32'hC9, 1'b0, 5'd0, 32'd0); tick();
      chk("kill_ex_strobe", ld_bar, ~(32'd1 << 9));
      chk("kill_ex_data", wr_data, 32'hC9);
      chk("kill_pend_clr", pend_mask, 32'd0);
      idle(); tick();
      chk("kill_no_restrobe", ld_bar, 32'hFFFF_FFFF);

      // same-cycle dm and ex to r9
      set_in(1'b1, 5'd9, 32'hD9, 1'b1, 5'd9, 32'hE9); tick();
      chk("same_ex_data", wr_data, 32'hD9);
      idle(); tick();
      chk("same_no_dm", ld_bar, 32'hFFFF_FFFF);
      tick();

      // starvation
      set_in(1'b1, 5'd4, 32'h44, 1'b1, 5'd11, 32'hB11); tick();
      set_in(1'b1, 5'd5, 32'h55, 1'b0, 5'd0, 32'd0); tick();
      chk("starve_c1", {31'b0, ex_stall}, 32'd0);
      set_in(1'b1, 5'd6, 32'h66, 1'b0, 5'd0, 32'd0); tick();
      chk("starve_c2", {31'b0, ex_stall}, 32'd0);
      set_in(1'b1, 5'd8, 32'h88, 1'b0, 5'd0, 32'd0); tick();
      chk("starve_rise", {31'b0, ex_stall}, 32'd1);
      set_in(1'b1, 5'd10, 32'hA0, 1'b0, 5'd0, 32'd0); tick();
      chk("starve_head_wr", ld_bar, ~(32'd1 << 11));
      chk("starve_fall", {31'b0, ex_stall}, 32'd0);
      tick();
      chk("starve_held_wr", ld_bar, ~(32'd1 << 10));
      chk("starve_held_data", wr_data, 32'hA0);
      idle(); tick();

      // backpressure with an illegal third return
      set_in(1'b1, 5'd20, 32'h20, 1'b1, 5'd12, 32'hC12); tick();
      set_in(1'b1, 5'd21, 32'h21, 1'b1, 5'd13, 32'hC13); tick();
      chk("bp_not_ready", {31'b0, dm_ready}, 32'd0);
      set_in(1'b1, 5'd22, 32'h22, 1'b1, 5'd14, 32'hC14); tick();
      chk("bp_ignored", pend_mask, (32'd1 << 12) | (32'd1 << 13));
      idle(); tick();
      chk("bp_first", ld_bar, ~(32'd1 << 12));
      chk("bp_first_data", wr_data, 32'hC12);
      tick();
      chk("bp_second", ld_bar, ~(32'd1 << 13));
      tick();
      chk("bp_drained", pend_mask, 32'd0);

      // reset mid-stream with two entries queued
      set_in(1'b1, 5'd20, 32'h20, 1'b1, 5'd12, 32'hC12); tick();
      set_in(1'b1, 5'd21, 32'h21, 1'b1, 5'd13, 32'hC13); tick();
      reset_l = 1'b0;
      set_in(1'b1, 5'd15, 32'hF15, 1'b0, 5'd0, 32'd0); tick();
      chk("mrst_ld_bar", ld_bar, 32'hFFFF_FFFF);
      chk("mrst_pend", pend_mask, 32'd0);
      chk("mrst_ready", {31'b0, dm_ready}, 32'd1);
      reset_l = 1'b1;
      idle();
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("mrst_nostrobe", ld_bar, 32'hFFFF_FFFF);
      end

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         reset_l = ($urandom_range(0, 299) != 0);
         if (!(m_stall && ex_valid)) begin
            ex_valid = ($urandom_range(0, 9) < 6);
            ex_addr  = pick();
            ex_data  = $urandom;
         end
         dm_valid = m_ready && ($urandom_range(0, 9) < 4);
         dm_addr  = pick();
         dm_data  = $urandom;
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/rsp_ld_arb.md
# rsp_ld_arb

Write-port load arbiter for the RSP 32-entry scalar register latch array. Accepts register writebacks from the execute stage (ALU results) and from the data-memory return path (loads), buffers memory returns that lose arbitration, resolves write-after-write ordering, and drives one active-low load strobe per register. `ld_bar` feeds the per-bit NOR clock gates, where `en_t = ~(ld_bar | clk)`, so the arbiter owns every write into the array.

## Interface
- `NREG`, 32: registers in the array; entry 0 is hardwired zero.
- `DW`, 32: data width.
- `QDEPTH`, 2: memory-return holding queue depth.
- `STARVE_MAX`, 4: cycles a queued return may wait before execute is stalled.

Ports:
- `clk` in 1: single clock.
- `reset_l` in 1: synchronous, active-low reset.
- `ex_valid` in 1: execute writeback request.
- `ex_addr` in 5: execute destination register.
- `ex_data` in DW: execute result.
- `ex_stall` out 1: execute request not accepted this cycle; upstream holds `ex_*` stable.
- `dm_valid` in 1: memory return request.
- `dm_addr` in 5: memory return destination register.
- `dm_data` in DW: memory return data.
- `dm_ready` out 1: queue can absorb a return; `dm_valid` is legal only when `dm_ready` = 1.
- `ld_bar` out NREG: active-low, at most one bit low.
- `wr_data` out DW: data presented to the array.
- `wr_src` out 1: 0 = execute, 1 = memory.
- `pend_mask` out NREG: registers with a queued memory write, used for the interlock.

## Operation
- Execute accept: `ex_valid & ~ex_stall`.
- Memory accept: `dm_valid & dm_ready`.
- Age rule: a memory return is always older than a concurrent or later execute write.
- Selection, evaluated once per cycle:
  - If `ex_stall` = 1, the queue head writes.
  - Else if execute is accepted, execute writes.
  - Else if the queue is non-empty, the head writes.
  - Else if `dm_valid`, memory writes directly (bypass).
  - Else nothing writes.
- A losing, non-killed memory return is enqueued at the tail. The queue is FIFO.
- WAW kill:
  - An accepted execute write to address A invalidates every queue entry with address A.
  - It also drops a same-cycle `dm` request to A. That request counts as accepted but is not enqueued.
- Address 0: accepted, never produces a strobe, never enqueued.
- Starvation:
  - Head age counter increments each cycle the head exists and does not write; it resets on head pop.
  - `ex_stall` = 1 when age ≥ STARVE_MAX − 1, registered.
  - It drops the cycle after the head writes.
- `dm_ready` = (occupancy < QDEPTH), registered from next-state occupancy.
- `pend_mask` = OR of one-hot addresses of valid queue entries, registered.

## Timing
- Request sampled at the rising edge of cycle N. `ld_bar` and `wr_data` are driven from flops in cycle N+1, so `ld_bar` is stable throughout the high phase of clk before the low-phase gated enable.
- `ld_bar` never changes except at a rising edge, so there are no glitches into the NOR gates.
- Queue latency: an enqueued return writes at the earliest cycle in which it is the head and execute does not win.
- Reset (`reset_l` = 0 at an edge) gives the following values next cycle:
  - `ld_bar` all 1; `wr_data` 0; `wr_src` 0.
  - `ex_stall` 0; `dm_ready` 1; `pend_mask` 0.
  - Queue emptied; age 0.
  - Requests present during reset are discarded.
- Queue full with an incoming return: protocol error. The request is ignored and does not corrupt the queue.
- Kill and pop of the same entry in the same cycle: pop wins and the write occurs. This cannot happen for a write in the same cycle, since the winner is unique.

## Structure
- Package `rsp_ld_pkg`:
  - `RSP_NREG`, `RSP_RADDR_W` = 5.
  - Enum `ld_src_t` {LD_SRC_EX, LD_SRC_DM}.
  - Function `onehot5` for 5-to-32 decode.
- Sub-module `rsp_ld_q`:
  - QDEPTH-entry {valid, addr, data} queue with push, pop, and address-match kill.
  - Exports head, occupancy, and pend mask.
- The top level holds the arbitration, age counter, and output flops.

## Test plan
- Reset behaviour: reset mid-stream with 2 entries queued and `ex_valid` = 1 → next cycle `ld_bar` = 32'hFFFFFFFF, `pend_mask` = 0, `dm_ready` = 1, no strobe afterwards.
- Simple writes:
  - Execute only, `ex_addr` = 5, data 0xDEADBEEF → cycle N+1 `ld_bar` = ~(1<<5), `wr_data` = 0xDEADBEEF, `wr_src` = 0.
  - Address 0 writes from either source → no strobe.
- Collision: `ex` to r3 and `dm` to r7 in the same cycle → r3 writes at N+1, r7 writes at N+2 with `wr_src` = 1. `pend_mask` bit 7 is set during N+1.
- WAW kill:
  - Queue holds r9, then `ex` writes r9 → the queued entry vanishes, `pend_mask[9]` clears, and r9 is strobed exactly once, with execute data.
  - Same-cycle `dm` to r9 and `ex` to r9 → only execute data is written.
- Starvation: `ex_valid` held continuously with one queued return → `ex_stall` rises after STARVE_MAX − 1 cycles, the head writes, `ex_stall` falls, and the held execute request writes next.
- Backpressure: 2 returns queue behind continuous execute writes → `dm_ready` = 0. An illegal third `dm_valid` is ignored. Both queued entries drain in FIFO order.
